// File: rtl/muldiv_ctrl.sv
// HI/LO sequencer: iterative shift-add multiply and restoring divide with sign fix-up,
// plus direct MTHI/MTLO writes. busy stalls dependent instructions until done.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO write here, mult/div ops are accepted here
// RUN   | one multiply/divide bit per cycle, WIDTH cycles
// FIX   | sign correction, HI/LO write, done pulse
module muldiv_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [5:0]       fncode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;
   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MTLO  = 6'h13;

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t             state;
   logic [CW-1:0]      cnt;
   logic               op_div;
   logic               sign_a;
   logic               sign_b;
   logic               b_zero;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   quot;

   logic               is_signed;
   logic [WIDTH-1:0]   abs_a;
   logic [WIDTH-1:0]   abs_b;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic               div_ge;
   logic [WIDTH-1:0]   div_diff;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix;
   logic [WIDTH-1:0]   rem_fix;
   logic [WIDTH-1:0]   fix_hi;
   logic [WIDTH-1:0]   fix_lo;

   always_comb begin
      is_signed = (fncode == F_MULT) || (fncode == F_DIV);
      abs_a     = (is_signed && a[WIDTH-1]) ? -a : a;
      abs_b     = (is_signed && b[WIDTH-1]) ? -b : b;

      mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mag_a} : '0);

      // difference only used when it fits, so the top bit can be dropped
      div_shift = {rem, quot[WIDTH-1]};
      div_ge    = div_shift >= {1'b0, mag_b};
      div_diff  = div_shift[WIDTH-1:0] - mag_b;

      prod_fix  = (sign_a ^ sign_b) ? -prod : prod;
      quot_fix  = (sign_a ^ sign_b) ? -quot : quot;
      rem_fix   = sign_a ? -rem : rem;

      // divide by zero leaves rem == |a|, so rem_fix restores a itself
      fix_hi    = op_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
      fix_lo    = op_div ? (b_zero ? '1 : quot_fix) : prod_fix[WIDTH-1:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         op_div <= 1'b0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         b_zero <= 1'b0;
         mag_a  <= '0;
         mag_b  <= '0;
         prod   <= '0;
         rem    <= '0;
         quot   <= '0;
         hi     <= '0;
         lo     <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  case (fncode)
                     F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                        op_div <= (fncode == F_DIV) || (fncode == F_DIVU);
                        sign_a <= is_signed & a[WIDTH-1];
                        sign_b <= is_signed & b[WIDTH-1];
                        b_zero <= (b == '0);
                        mag_a  <= abs_a;
                        mag_b  <= abs_b;
                        prod   <= {{WIDTH{1'b0}}, abs_b};
                        rem    <= '0;
                        quot   <= abs_a;
                        cnt    <= CW'(WIDTH - 1);
                        busy   <= 1'b1;
                        state  <= RUN;
                     end
                     F_MTHI:  hi <= a;
                     F_MTLO:  lo <= a;
                     default: ;
                  endcase
               end
            end
            RUN: begin
               if (op_div) begin
                  rem  <= div_ge ? div_diff : div_shift[WIDTH-1:0];
                  quot <= {quot[WIDTH-2:0], div_ge};
               end else begin
                  prod <= {mul_sum, prod[WIDTH-1:1]};
               end
               if (cnt == '0) state <= FIX;
               else           cnt   <= cnt - CW'(1);
            end
            FIX: begin
               hi    <= fix_hi;
               lo    <= fix_lo;
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: vector table of mult/div results plus
// hand-written MTHI/MTLO, busy-injection and mid-run reset sequences.
module tb_muldiv_ctrl;

   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;
   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MTLO  = 6'h13;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [5:0]  fncode;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [5:0]  fn;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t vecs[13];

   muldiv_ctrl #(.WIDTH(32)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .fncode (fncode),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .hi     (hi),
      .lo     (lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Issue a mult/div op and follow it to completion; optionally inject a
   // start/MTHI at run cycle inj and confirm hi still holds `hold` after it.
   task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] ehi, input logic [31:0] elo,
                         input int inj, input logic [31:0] hold);
      int busy_n  = 0;
      int done_at = -1;
      @(negedge clk);
      start = 1'b1; fncode = f; a = av; b = bv;
      @(posedge clk);
      #1;
      start = 1'b0; a = ~av; b = bv ^ 32'h5A5A_5A5A;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (inj >= 0 && k == inj + 1) begin
            start = 1'b0;
            check({name, " hi_hold"}, hi, hold);
         end
         if (done) begin
            done_at = k;
            break;
         end
         if (busy) busy_n++;
         if (inj >= 0 && k == inj) begin
            start = 1'b1; fncode = F_MTHI; a = 32'h0000_DEAD;
         end
      end
      start = 1'b0;
      check({name, " busy_cycles"}, 32'(busy_n), 32'd33);
      check({name, " done_latency"}, 32'(done_at), 32'd33);
      check({name, " busy_at_done"}, {31'd0, busy}, 32'd0);
      check({name, " hi"}, hi, ehi);
      check({name, " lo"}, lo, elo);
      @(negedge clk);
      check({name, " done_single"}, {31'd0, done}, 32'd0);
   endtask

   task automatic write_reg(input logic [5:0] f, input logic [31:0] av);
      @(negedge clk);
      start = 1'b1; fncode = f; a = av;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      vecs[0]  = '{F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
      vecs[1]  = '{F_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
      vecs[2]  = '{F_DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
      vecs[3]  = '{F_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vecs[4]  = '{F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
      vecs[5]  = '{F_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
      vecs[6]  = '{F_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF};
      vecs[7]  = '{F_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
      vecs[8]  = '{F_MULT,  32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
      vecs[9]  = '{F_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
      vecs[10] = '{F_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1,         32'd0};
      vecs[11] = '{F_DIVU,  32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF};
      vecs[12] = '{F_MULT,  32'd0,         32'hFFFF_FFFB, 32'd0,         32'd0};

      reset = 1'b1; start = 1'b0; fncode = 6'h00; a = '0; b = '0;
      repeat (3) @(negedge clk);
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset done", {31'd0, done}, 32'd0);
      check("reset hi", hi, 32'd0);
      check("reset lo", lo, 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 13; i++)
         run_op($sformatf("vec%0d", i), vecs[i].fn, vecs[i].a, vecs[i].b,
                vecs[i].hi, vecs[i].lo, -1, 32'd0);

      // MTLO/MTHI while idle: immediate write, no busy/done
      write_reg(F_MTLO, 32'h1234_5678);
      check("mtlo lo", lo, 32'h1234_5678);
      check("mtlo hi_kept", hi, 32'd0);
      check("mtlo busy", {31'd0, busy}, 32'd0);
      check("mtlo done", {31'd0, done}, 32'd0);
      write_reg(F_MTHI, 32'h0000_CAFE);
      check("mthi hi", hi, 32'h0000_CAFE);
      check("mthi lo_kept", lo, 32'h1234_5678);

      // unknown funct is ignored
      write_reg(6'h20, 32'h9999_9999);
      check("badfn busy", {31'd0, busy}, 32'd0);
      check("badfn hi", hi, 32'h0000_CAFE);
      check("badfn lo", lo, 32'h1234_5678);

      // MTHI attempted mid-MULT is ignored
      run_op("inject", F_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 5, 32'h0000_CAFE);

      // reset during a DIV aborts with no done pulse
      write_reg(F_MTHI, 32'h0BAD_0BAD);
      @(negedge clk);
      start = 1'b1; fncode = F_DIV; a = 32'd1000; b = 32'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      check("pre_reset busy", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      #1;
      check("midreset busy", {31'd0, busy}, 32'd0);
      check("midreset hi", hi, 32'd0);
      check("midreset lo", lo, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      begin
         int seen = 0;
         for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done || busy) seen++;
         end
         check("midreset no_done", 32'(seen), 32'd0);
      end
      run_op("after_reset", F_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, -1, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
